hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It generates the one-hot `reg_mux_sel`-style selects that drive the IF/ID and ID/EX pipeline registers: 001 normal, 010 flush/bubble, 100 stall/hold. It also generates the PC hold and the EX-stage operand forwarding selects. It tracks destination registers of instructions in MEM and WB internally, and keeps saturating stall/flush event counters.

## Interface
- `CNT_W`, 16, width of each saturating event counter
- `clk`  in  1  pipeline clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high; clears all internal state immediately
- `inst_ID`  in  32  instruction currently in ID
- `inst_Ex`  in  32  instruction currently in EX (output of ID/EX register); 0 = bubble
- `br_taken_Ex`  in  1  branch taken / JAL / JALR resolved in EX this cycle
- `mem_stall`  in  1  data memory not ready; freeze entire pipeline this cycle
- `if_id_sel`  out  3  one-hot select for IF/ID register
- `id_ex_sel`  out  3  one-hot select for ID/EX register (`reg_mux_sel` of ID stage)
- `pc_stall`  out  1  1 = PC holds its value this cycle
- `fwd_a_sel`  out  2  EX rs1 source: 00 regfile, 01 MEM result, 10 WB result
- `fwd_b_sel`  out  2  EX rs2 source, same encoding
- `stall_count`  out  CNT_W  number of load-use stall cycles, saturating
- `flush_count`  out  CNT_W  number of branch flush cycles, saturating

## Operation
- Decode helpers apply to a 32-bit instruction word, with opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - writes_rd: opcode in {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111} and rd != 0.
  - uses_rs1: opcode in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111}.
  - uses_rs2: opcode in {0110011, 0100011, 1100011}.
  - is_load: opcode == 0000011.
  - The all-zero word decodes as a bubble: no write, no uses.
- Internal tracking holds two slots, MEM and WB. Each slot holds {valid_wr, rd}.
  - On each posedge with mem_stall=0: MEM <= decode(inst_Ex), and WB <= MEM.
  - On a posedge with mem_stall=1: both slots hold.
- Forwarding for rs1 (rs2 identical, using `fwd_b_sel`):
  - If uses_rs1(inst_Ex) and MEM.valid_wr and MEM.rd == rs1(inst_Ex): 01.
  - Else if the same test passes against WB: 10.
  - Else: 00.
  - MEM has priority over WB.
  - rd = 0 never forwards.
- load_use = is_load(inst_Ex) and writes_rd(inst_Ex) and [(uses_rs1(inst_ID) and rs1(inst_ID) == rd(inst_Ex)) or (uses_rs2(inst_ID) and rs2(inst_ID) == rd(inst_Ex))].
- Control state, evaluated in strict priority:
  - HOLD (mem_stall=1): `if_id_sel`=100, `id_ex_sel`=100, `pc_stall`=1.
  - FLUSH (br_taken_Ex=1): `if_id_sel`=010, `id_ex_sel`=010, `pc_stall`=0.
  - LU_STALL (load_use=1): `if_id_sel`=100, `id_ex_sel`=010, `pc_stall`=1.
  - RUN: 001 / 001 / 0.
- Counters increment at posedge only, and saturate at all-ones:
  - `flush_count` +1 per cycle in FLUSH.
  - `stall_count` +1 per cycle in LU_STALL.
  - HOLD cycles are not counted.

## Timing
- All outputs are combinational from the inputs and registered state, and valid in the same cycle. The pipeline registers sample them at the next posedge.
- A load-use stall lasts exactly one cycle. The next cycle has a bubble in EX, so load_use deasserts. The consumer then reaches EX while the load is in WB, and forwarding selects 10.
- FLUSH and load_use in the same cycle: FLUSH wins, and `stall_count` does not increment.
- mem_stall and br_taken_Ex in the same cycle: HOLD wins. The flush occurs on the first cycle mem_stall=0 while br_taken_Ex is still asserted.
- While `reset`=1, regardless of clk:
  - `if_id_sel`=010, `id_ex_sel`=010, `pc_stall`=1.
  - `fwd_a_sel` = `fwd_b_sel` = 00.
  - Both tracking slots are invalid; both counters are 0.
- Deassertion of reset: the first posedge after deassertion performs a normal update.
- Reset asserted mid-stall or mid-flush aborts the stall or flush immediately, with no counter update.
- Selects are always exactly one-hot; 000 and multi-hot values are never driven.

## Test plan
- Reset and run:
  - Assert reset mid-cycle → outputs immediately 010/010/1, fwd 00/00, counters 0.
  - Release and drive bubbles → 001/001/0.
- Forwarding chain:
  - Drive `add x5,x1,x2` in EX, then `sub x6,x5,x3` in EX the next cycle → `fwd_a_sel`=01, `fwd_b_sel`=00.
  - Then `or x7,x4,x5` in EX the following cycle → `fwd_b_sel`=10.
- Load-use stall:
  - Drive `lw x6,0(x1)` in EX with `add x7,x6,x1` in ID → one cycle of if_id 100, id_ex 010, `pc_stall`=1, and `stall_count`=1.
  - Two cycles later, with the add in EX → `fwd_a_sel`=10.
- Flush priority:
  - Drive `br_taken_Ex`=1 with a load-use pair present → 010/010/`pc_stall`=0, `flush_count`=1, `stall_count` unchanged.
- Memory hold:
  - Hold `mem_stall`=1 for 3 cycles with `br_taken_Ex`=1 → 100/100/1 for 3 cycles, with tracking slots and forwarding unchanged.
  - On the 4th cycle → FLUSH.
- x0 and saturation:
  - Drive `addi x0,x0,1` followed by a consumer of x0 → no forwarding (00).
  - With `CNT_W`=4, apply 20 load-use stalls → `stall_count`=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard controller: stall/flush selects, PC hold, EX forwarding
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_ID,
    input  logic [31:0]      inst_Ex,
    input  logic             br_taken_Ex,
    input  logic             mem_stall,
    output logic [2:0]       if_id_sel,
    output logic [2:0]       id_ex_sel,
    output logic             pc_stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] SEL_RUN   = 3'b001;
    localparam logic [2:0] SEL_FLUSH = 3'b010;
    localparam logic [2:0] SEL_HOLD  = 3'b100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_HOLD,
        CTRL_FLUSH,
        CTRL_LU_STALL
    } ctrl_t;

    typedef struct packed {
        logic       valid_wr;
        logic [4:0] rd;
    } slot_t;

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic wr;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: wr = 1'b1;
            default:                                                  wr = 1'b0;
        endcase
        return wr && (rd != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // MEM is checked before WB so the youngest producer wins
    function automatic logic [1:0] fwd_select(input logic used, input logic [4:0] rs,
                                              input slot_t mem_s, input slot_t wb_s);
        if (used && mem_s.valid_wr && mem_s.rd == rs) return FWD_MEM;
        if (used && wb_s.valid_wr && wb_s.rd == rs)   return FWD_WB;
        return FWD_RF;
    endfunction

    logic [6:0] op_id;
    logic [6:0] op_ex;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic [4:0] rd_ex;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic       unused_fields;

    assign op_id  = inst_ID[6:0];
    assign rs1_id = inst_ID[19:15];
    assign rs2_id = inst_ID[24:20];
    assign op_ex  = inst_Ex[6:0];
    assign rd_ex  = inst_Ex[11:7];
    assign rs1_ex = inst_Ex[19:15];
    assign rs2_ex = inst_Ex[24:20];

    assign unused_fields = ^{inst_ID[31:25], inst_ID[14:7], inst_Ex[31:25], inst_Ex[14:12]};

    slot_t mem_slot;
    slot_t wb_slot;
    ctrl_t ctrl;
    logic  load_use;

    always_comb begin
        load_use = 1'b0;
        if (op_ex == OP_LOAD && writes_rd(op_ex, rd_ex)) begin
            load_use = (uses_rs1(op_id) && rs1_id == rd_ex) ||
                       (uses_rs2(op_id) && rs2_id == rd_ex);
        end
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (mem_stall) begin
            ctrl = CTRL_HOLD;
        end else if (br_taken_Ex) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            ctrl = CTRL_LU_STALL;
        end
    end

    // Reset forces a bubble into both registers and freezes the PC without waiting for a clock
    always_comb begin
        if_id_sel = SEL_RUN;
        id_ex_sel = SEL_RUN;
        pc_stall  = 1'b0;
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (reset) begin
            if_id_sel = SEL_FLUSH;
            id_ex_sel = SEL_FLUSH;
            pc_stall  = 1'b1;
        end else begin
            fwd_a_sel = fwd_select(uses_rs1(op_ex), rs1_ex, mem_slot, wb_slot);
            fwd_b_sel = fwd_select(uses_rs2(op_ex), rs2_ex, mem_slot, wb_slot);
            case (ctrl)
                CTRL_HOLD: begin
                    if_id_sel = SEL_HOLD;
                    id_ex_sel = SEL_HOLD;
                    pc_stall  = 1'b1;
                end
                CTRL_FLUSH: begin
                    if_id_sel = SEL_FLUSH;
                    id_ex_sel = SEL_FLUSH;
                end
                CTRL_LU_STALL: begin
                    if_id_sel = SEL_HOLD;
                    id_ex_sel = SEL_FLUSH;
                    pc_stall  = 1'b1;
                end
                default: begin
                    if_id_sel = SEL_RUN;
                    id_ex_sel = SEL_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_slot <= '0;
            wb_slot  <= '0;
        end else if (!mem_stall) begin
            mem_slot <= '{valid_wr: writes_rd(op_ex, rd_ex), rd: rd_ex};
            wb_slot  <= mem_slot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (ctrl == CTRL_LU_STALL && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (ctrl == CTRL_FLUSH && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
